// File: rtl/rs_dispatch_scheduler_pkg.sv
// Shared types and defaults for the ROB-to-reservation-station dispatch path.
package rs_dispatch_scheduler_pkg;

  localparam int RS_SIZE_DEF   = 8;
  localparam int CRED_W_DEF    = 4;
  localparam int PAYLOAD_W_DEF = 160;
  localparam int STAT_W        = 32;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_LS  = 2'd1,
    FU_MUL = 2'd2,
    FU_BR  = 2'd3
  } fu_t;

  typedef logic [PAYLOAD_W_DEF-1:0] dispatch_payload_t;

  // Only the ALU and LS stations exist behind this scheduler.
  function automatic logic fu_is_dispatchable(input fu_t fu);
    return (fu == FU_ALU) || (fu == FU_LS);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}})) begin
      return v + STAT_W'(1);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/rs_dispatch_scheduler_credit.sv
// rs_credit_counter: free-entry counter for one reservation station, with
// flush-to-full and a sticky error for releases that would overflow.
module rs_credit_counter
  import rs_dispatch_scheduler_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int CRED_W  = CRED_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              drain_i,
  input  logic              release_i,
  input  logic              flush_i,
  output logic [CRED_W-1:0] credit_o,
  output logic              err_o
);

  localparam logic [CRED_W-1:0] FULL = CRED_W'(RS_SIZE);

  logic [CRED_W-1:0] credit_q, credit_d;
  logic              err_q, err_d;

  // Next credit value; a flush restores full credit but keeps the error flag.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (flush_i) begin
      credit_d = FULL;
    end else begin
      case ({drain_i, release_i})
        2'b10: credit_d = credit_q - CRED_W'(1);
        2'b01: begin
          if (credit_q == FULL) begin
            err_d = 1'b1;
          end else begin
            credit_d = credit_q + CRED_W'(1);
          end
        end
        default: credit_d = credit_q;
      endcase
    end
  end

  // Credit and error state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      credit_q <= FULL;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign credit_o = credit_q;
  assign err_o    = err_q;

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// Credit-based steering of ROB dispatches into the ALU / LS reservation stations.
// Optional statistics counters are built when RS_DISPATCH_STATS_EN is defined.
module rs_dispatch_scheduler
  import rs_dispatch_scheduler_pkg::*;
#(
  parameter int RS_SIZE   = RS_SIZE_DEF,
  parameter int CRED_W    = CRED_W_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_rob_done,
  input  fu_t                  in_rob_fu_id,
  input  logic [PAYLOAD_W-1:0] in_rob_payload,
  input  logic                 in_rob_is_mispred,
  input  logic                 in_alu_rs_release,
  input  logic                 in_ls_rs_release,
  output logic                 out_rob_stall,
  output logic                 out_alu_rs_valid,
  output logic                 out_ls_rs_valid,
  output logic [PAYLOAD_W-1:0] out_rs_payload,
  output logic [CRED_W-1:0]    out_alu_credits,
  output logic [CRED_W-1:0]    out_ls_credits,
  output logic                 out_credit_err
`ifdef RS_DISPATCH_STATS_EN
  ,
  output logic [STAT_W-1:0]    out_stat_alu_disp,
  output logic [STAT_W-1:0]    out_stat_ls_disp,
  output logic [STAT_W-1:0]    out_stat_stall_cycles
`endif
);

  logic                 hold_valid_q, hold_valid_d;
  fu_t                  hold_fu_q, hold_fu_d;
  logic [PAYLOAD_W-1:0] hold_payload_q, hold_payload_d;

  logic [CRED_W-1:0] alu_credit_s, ls_credit_s;
  logic              alu_err_s, ls_err_s;
  logic              has_credit_s, drain_s, stall_s, accept_s;
  logic              drain_alu_s, drain_ls_s;

  // Does the station targeted by the held dispatch have a free entry?
  always_comb begin
    has_credit_s = 1'b0;
    case (hold_fu_q)
      FU_ALU:  has_credit_s = (alu_credit_s != '0);
      FU_LS:   has_credit_s = (ls_credit_s != '0);
      default: has_credit_s = 1'b0;
    endcase
  end

  assign drain_s     = hold_valid_q & has_credit_s & ~in_rob_is_mispred;
  assign stall_s     = hold_valid_q & ~drain_s & ~in_rob_is_mispred;
  assign accept_s    = in_rob_done & ~stall_s & ~in_rob_is_mispred & fu_is_dispatchable(in_rob_fu_id);
  assign drain_alu_s = drain_s & (hold_fu_q == FU_ALU);
  assign drain_ls_s  = drain_s & (hold_fu_q == FU_LS);

  // Holding register next state; an accept may refill in the cycle it drains.
  always_comb begin
    hold_valid_d   = hold_valid_q;
    hold_fu_d      = hold_fu_q;
    hold_payload_d = hold_payload_q;
    if (in_rob_is_mispred) begin
      hold_valid_d = 1'b0;
    end else if (accept_s) begin
      hold_valid_d   = 1'b1;
      hold_fu_d      = in_rob_fu_id;
      hold_payload_d = in_rob_payload;
    end else if (drain_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Holding register.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      hold_valid_q   <= 1'b0;
      hold_fu_q      <= FU_ALU;
      hold_payload_q <= '0;
    end else begin
      hold_valid_q   <= hold_valid_d;
      hold_fu_q      <= hold_fu_d;
      hold_payload_q <= hold_payload_d;
    end
  end

  rs_credit_counter #(
    .RS_SIZE (RS_SIZE),
    .CRED_W  (CRED_W)
  ) u_alu_credit (
    .clk_i     (in_clk),
    .rst_n_i   (in_rst_n),
    .drain_i   (drain_alu_s),
    .release_i (in_alu_rs_release),
    .flush_i   (in_rob_is_mispred),
    .credit_o  (alu_credit_s),
    .err_o     (alu_err_s)
  );

  rs_credit_counter #(
    .RS_SIZE (RS_SIZE),
    .CRED_W  (CRED_W)
  ) u_ls_credit (
    .clk_i     (in_clk),
    .rst_n_i   (in_rst_n),
    .drain_i   (drain_ls_s),
    .release_i (in_ls_rs_release),
    .flush_i   (in_rob_is_mispred),
    .credit_o  (ls_credit_s),
    .err_o     (ls_err_s)
  );

  assign out_rob_stall    = stall_s;
  assign out_alu_rs_valid = drain_alu_s;
  assign out_ls_rs_valid  = drain_ls_s;
  assign out_rs_payload   = hold_valid_q ? hold_payload_q : '0;
  assign out_alu_credits  = alu_credit_s;
  assign out_ls_credits   = ls_credit_s;
  assign out_credit_err   = alu_err_s | ls_err_s;

`ifdef RS_DISPATCH_STATS_EN
  logic [STAT_W-1:0] stat_alu_q, stat_alu_d;
  logic [STAT_W-1:0] stat_ls_q, stat_ls_d;
  logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

  // Saturating event counters; only reset clears them.
  always_comb begin
    stat_alu_d   = sat_inc(stat_alu_q, drain_alu_s);
    stat_ls_d    = sat_inc(stat_ls_q, drain_ls_s);
    stat_stall_d = sat_inc(stat_stall_q, stall_s);
  end

  // Statistics registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      stat_alu_q   <= '0;
      stat_ls_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_alu_q   <= stat_alu_d;
      stat_ls_q    <= stat_ls_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign out_stat_alu_disp     = stat_alu_q;
  assign out_stat_ls_disp      = stat_ls_q;
  assign out_stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_rs_dispatch_scheduler.sv
// Scoreboard bench for rs_dispatch_scheduler: directed scenarios plus random traffic
// checked against a queue-based model of the holding slot and station occupancy.
module tb_rs_dispatch_scheduler;
  import rs_dispatch_scheduler_pkg::*;

  localparam int PW = PAYLOAD_W_DEF;
  localparam int RS = RS_SIZE_DEF;

  logic          in_clk = 1'b0;
  logic          in_rst_n;
  logic          in_rob_done;
  fu_t           in_rob_fu_id;
  logic [PW-1:0] in_rob_payload;
  logic          in_rob_is_mispred;
  logic          in_alu_rs_release;
  logic          in_ls_rs_release;
  logic          out_rob_stall;
  logic          out_alu_rs_valid;
  logic          out_ls_rs_valid;
  logic [PW-1:0] out_rs_payload;
  logic [CRED_W_DEF-1:0] out_alu_credits;
  logic [CRED_W_DEF-1:0] out_ls_credits;
  logic          out_credit_err;
`ifdef RS_DISPATCH_STATS_EN
  logic [31:0]   out_stat_alu_disp, out_stat_ls_disp, out_stat_stall_cycles;
`endif

  always #5 in_clk = ~in_clk;

  rs_dispatch_scheduler dut (
    .in_clk            (in_clk),
    .in_rst_n          (in_rst_n),
    .in_rob_done       (in_rob_done),
    .in_rob_fu_id      (in_rob_fu_id),
    .in_rob_payload    (in_rob_payload),
    .in_rob_is_mispred (in_rob_is_mispred),
    .in_alu_rs_release (in_alu_rs_release),
    .in_ls_rs_release  (in_ls_rs_release),
    .out_rob_stall     (out_rob_stall),
    .out_alu_rs_valid  (out_alu_rs_valid),
    .out_ls_rs_valid   (out_ls_rs_valid),
    .out_rs_payload    (out_rs_payload),
    .out_alu_credits   (out_alu_credits),
    .out_ls_credits    (out_ls_credits),
    .out_credit_err    (out_credit_err)
`ifdef RS_DISPATCH_STATS_EN
    ,
    .out_stat_alu_disp     (out_stat_alu_disp),
    .out_stat_ls_disp      (out_stat_ls_disp),
    .out_stat_stall_cycles (out_stat_stall_cycles)
`endif
  );

  typedef struct {
    fu_t               fu;
    dispatch_payload_t payload;
  } item_t;

  typedef struct {
    logic stall;
    int   alu_c;
    int   ls_c;
    logic err;
    logic hold_empty;
    int   s_alu;
    int   s_ls;
    int   s_stall;
  } status_t;

  item_t   exp_q[$];
  status_t stat_q[$];

  // Reference model: the holding slot is a queue of at most one dispatch,
  // free entries are plain integers per station (0 = ALU, 1 = LS).
  item_t m_hold[$];
  int    m_cred[2];
  logic  m_err;
  int    m_sa, m_sl, m_ss;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold.delete();
    m_cred[0] = RS;
    m_cred[1] = RS;
    m_err = 1'b0;
    m_sa = 0;
    m_sl = 0;
    m_ss = 0;
  endtask

  task automatic cycle(input logic done, input fu_t fu, input logic mp, input logic ra, input logic rl);
    item_t   it;
    status_t st;
    logic    can, stall;
    int      f, c;
    int      rel[2];
    int      drn[2];
    @(negedge in_clk);
    it.fu      = fu;
    it.payload = {$urandom, $urandom, $urandom, $urandom, $urandom};
    in_rob_done       = done;
    in_rob_fu_id      = fu;
    in_rob_payload    = it.payload;
    in_rob_is_mispred = mp;
    in_alu_rs_release = ra;
    in_ls_rs_release  = rl;

    can = 1'b0;
    stall = 1'b0;
    f = 0;
    if (m_hold.size() > 0) begin
      f = (m_hold[0].fu == FU_LS) ? 1 : 0;
      can = (m_cred[f] > 0) && !mp;
      stall = !can && !mp;
    end
    st = '{stall, m_cred[0], m_cred[1], m_err, (m_hold.size() == 0), m_sa, m_sl, m_ss};
    stat_q.push_back(st);
    if (can) exp_q.push_back(m_hold[0]);

    if (can && f == 0) m_sa++;
    if (can && f == 1) m_sl++;
    if (stall) m_ss++;

    if (mp) begin
      m_hold.delete();
      m_cred[0] = RS;
      m_cred[1] = RS;
    end else begin
      rel[0] = ra ? 1 : 0;
      rel[1] = rl ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        drn[i] = (can && f == i) ? 1 : 0;
        c = m_cred[i] - drn[i] + rel[i];
        if (c > RS) begin
          c = RS;
          m_err = 1'b1;
        end
        m_cred[i] = c;
      end
      if (can) void'(m_hold.pop_front());
      if (done && !stall && (fu == FU_ALU || fu == FU_LS)) m_hold.push_back(it);
    end
  endtask

  task automatic do_reset();
    @(negedge in_clk);
    in_rst_n = 1'b0;
    in_rob_done = 1'b0;
    in_rob_is_mispred = 1'b0;
    in_alu_rs_release = 1'b0;
    in_ls_rs_release = 1'b0;
    #1;
    check("rst_stall", out_rob_stall, 0);
    check("rst_alu_valid", out_alu_rs_valid, 0);
    check("rst_ls_valid", out_ls_rs_valid, 0);
    check("rst_payload", out_rs_payload, 0);
    check("rst_alu_credits", out_alu_credits, RS);
    check("rst_ls_credits", out_ls_credits, RS);
    check("rst_err", out_credit_err, 0);
    model_reset();
    @(posedge in_clk);
    #1 in_rst_n = 1'b1;
  endtask

  // Monitor: compare per-cycle status and every RS write against the scoreboard.
  initial begin
    status_t st;
    item_t   it;
    forever begin
      @(negedge in_clk);
      #2;
      if (stat_q.size() > 0) begin
        st = stat_q.pop_front();
        check("stall", out_rob_stall, st.stall);
        check("alu_credits", out_alu_credits, st.alu_c);
        check("ls_credits", out_ls_credits, st.ls_c);
        check("credit_err", out_credit_err, st.err);
        if (st.hold_empty) check("idle_payload", out_rs_payload, 0);
`ifdef RS_DISPATCH_STATS_EN
        check("stat_alu", out_stat_alu_disp, st.s_alu);
        check("stat_ls", out_stat_ls_disp, st.s_ls);
        check("stat_stall", out_stat_stall_cycles, st.s_stall);
`endif
      end
      if (out_alu_rs_valid || out_ls_rs_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: alu=%0b ls=%0b expected no write", out_alu_rs_valid, out_ls_rs_valid);
        end else begin
          it = exp_q.pop_front();
          check("alu_valid", out_alu_rs_valid, it.fu == FU_ALU);
          check("ls_valid", out_ls_rs_valid, it.fu == FU_LS);
          check("payload", out_rs_payload, it.payload);
        end
      end else if (exp_q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL missing_write: got no write expected fu=%0d", exp_q[0].fu);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_rst_n = 1'b0;
    in_rob_done = 1'b0;
    in_rob_fu_id = FU_ALU;
    in_rob_payload = '0;
    in_rob_is_mispred = 1'b0;
    in_alu_rs_release = 1'b0;
    in_ls_rs_release = 1'b0;
    model_reset();
    do_reset();

    // Fill ALU station, 9th dispatch stalls; LS waits behind it; one release drains it.
    for (int i = 0; i < 9; i++) cycle(1'b1, FU_ALU, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, FU_LS, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, FU_LS, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, FU_LS, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, FU_ALU, 1'b0, 1'b0, 1'b0);

    // Drain and release together at credits 3, then overflowing LS release.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, FU_ALU, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, FU_ALU, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, FU_ALU, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, FU_ALU, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, FU_ALU, 1'b0, 1'b0, 1'b0);

    // Mispredict while stalled with ALU=0, LS=5.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, FU_LS, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, FU_ALU, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, FU_LS, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, FU_ALU, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, FU_ALU, 1'b0, 1'b0, 1'b0);

    // Invalid targets are dropped; reset in the middle of a stall.
    cycle(1'b1, FU_MUL, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, FU_BR, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, FU_ALU, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, FU_ALU, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 2; i++) cycle(1'b0, FU_ALU, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic d, mp, ra, rl;
      fu_t  fu;
      d  = ($urandom % 10) < 7;
      fu = (($urandom % 8) < 7) ? fu_t'(2'($urandom % 2)) : fu_t'(2'(2 + $urandom % 2));
      mp = ($urandom % 40) == 0;
      ra = (m_cred[0] < RS) ? (($urandom % 3) == 0) : (($urandom % 60) == 0);
      rl = (m_cred[1] < RS) ? (($urandom % 3) == 0) : (($urandom % 60) == 0);
      cycle(d, fu, mp, ra, rl);
      if (($urandom % 500) == 0) do_reset();
    end

    for (int i = 0; i < 3; i++) cycle(1'b0, FU_ALU, 1'b0, 1'b0, 1'b0);
    @(negedge in_clk);
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_writes: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
